// File: rtl/reg_intf_pkg.sv
// Shared reg_intf request/response types plus responder FSM state.
package reg_intf;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_intf_req_a32_d32;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_intf_resp_d32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } reg_intf_slv_state_e;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_intf_regfile_addr_decode.sv
// Address to register index decode with range, alignment and
// read-only write checks.
module reg_intf_addr_decode
  import reg_intf::*;
#(
  parameter logic [31:0]        BaseAddr     = 32'h0,
  parameter int unsigned        NumRegs      = 8,
  parameter logic [NumRegs-1:0] ReadOnlyMask = '0,
  parameter int unsigned        IdxW         = idx_width(NumRegs)
) (
  input  logic [31:0]     addr,
  input  logic            write,
  output logic [IdxW-1:0] idx,
  output logic            error
);

  logic [31:0] off;
  logic [31:0] word;
  logic        in_range;
  logic        ro;

  // BaseAddr is word aligned, so the offset's low bits are the address's
  assign off      = addr - BaseAddr;
  assign word     = {2'b00, off[31:2]};
  assign in_range = word < 32'(NumRegs);
  assign idx      = word[IdxW-1:0];
  assign ro       = in_range && write && ReadOnlyMask[idx];

  assign error = (off[1:0] != 2'b00)
              || (addr < BaseAddr)
              || !in_range
              || ro;

endmodule

// File: rtl/reg_intf_regfile.sv
// reg_intf responder: CSR bank with bus access, wait states and
// per-register hardware write ports.
module reg_intf_regfile
  import reg_intf::*;
#(
  parameter int unsigned           NumRegs      = 8,
  parameter logic [31:0]           BaseAddr     = 32'h0,
  parameter int unsigned           WaitCycles   = 0,
  parameter logic [NumRegs-1:0]    ReadOnlyMask = '0,
  parameter logic [NumRegs*32-1:0] ResetValue   = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  reg_intf_req_a32_d32     reg_req_i,
  output reg_intf_resp_d32        reg_rsp_o,
  input  logic [NumRegs-1:0]      hw_we_i,
  input  logic [NumRegs*32-1:0]   hw_wdata_i,
  output logic [NumRegs*32-1:0]   reg_q_o
);

  localparam int unsigned IdxW = idx_width(NumRegs);

  reg_intf_slv_state_e state;
  logic [3:0]          cnt;
  logic [31:0]         q   [NumRegs];
  logic [31:0]         nxt [NumRegs];
  logic [IdxW-1:0]     dec_idx;
  logic                dec_err;
  logic [IdxW-1:0]     idx_q;
  logic                err_q;
  logic                wr_q;
  logic [31:0]         rdata_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic                commit;

  reg_intf_addr_decode #(
    .BaseAddr     (BaseAddr),
    .NumRegs      (NumRegs),
    .ReadOnlyMask (ReadOnlyMask),
    .IdxW         (IdxW)
  ) u_dec (
    .addr  (reg_req_i.addr),
    .write (reg_req_i.write),
    .idx   (dec_idx),
    .error (dec_err)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (reg_req_i.valid) begin
            idx_q   <= dec_idx;
            err_q   <= dec_err;
            rdata_q <= dec_err ? 32'h0 : q[dec_idx];
            wr_q    <= reg_req_i.write & ~dec_err;
            wdata_q <= reg_req_i.wdata;
            wstrb_q <= reg_req_i.wstrb;
            cnt     <= 4'(WaitCycles);
            state   <= (WaitCycles == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!reg_req_i.valid) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
          wr_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign commit = (state == RESP) && wr_q;

  // Hardware word first, bus-strobed bytes override it on collision
  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      nxt[i] = hw_we_i[i] ? hw_wdata_i[32*i +: 32] : q[i];
      if (commit && idx_q == IdxW'(i)) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb_q[b]) nxt[i][8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumRegs; i++) begin
      if (rst_i) q[i] <= ResetValue[32*i +: 32];
      else       q[i] <= nxt[i];
    end
  end

  for (genvar i = 0; i < NumRegs; i++) begin : g_q
    assign reg_q_o[32*i +: 32] = q[i];
  end

  assign reg_rsp_o.ready = (state == RESP);
  assign reg_rsp_o.error = (state == RESP) ? err_q : 1'b0;
  assign reg_rsp_o.rdata = (state == RESP) ? rdata_q : 32'h0;

  a_valid_held : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (state == WAIT) |-> reg_req_i.valid
  );

endmodule

// File: tb/tb_reg_intf_regfile.sv
// Directed bench for reg_intf_regfile with 0, 2 and 3 wait states.
module tb_reg_intf_regfile;
  import reg_intf::*;

  localparam logic [127:0] RV =
    {32'h0, 32'h0, 32'hCAFE_F00D, 32'h0};
  localparam logic [3:0] RO = 4'b0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_ab;
  logic rst_c;
  reg_intf_req_a32_d32 req_a, req_b, req_c;
  reg_intf_resp_d32    rsp_a, rsp_b, rsp_c;
  logic [3:0]   hwe_a, hwe_b, hwe_c;
  logic [127:0] hwd_a, hwd_b, hwd_c;
  logic [127:0] q_a, q_b, q_c;

  int errors = 0;
  int checks = 0;

  reg_intf_regfile #(
    .NumRegs(4), .WaitCycles(0),
    .ReadOnlyMask(RO), .ResetValue(RV)
  ) u_a (
    .clk_i(clk), .rst_i(rst_ab),
    .reg_req_i(req_a), .reg_rsp_o(rsp_a),
    .hw_we_i(hwe_a), .hw_wdata_i(hwd_a),
    .reg_q_o(q_a)
  );

  reg_intf_regfile #(
    .NumRegs(4), .WaitCycles(3),
    .ReadOnlyMask(RO), .ResetValue(RV)
  ) u_b (
    .clk_i(clk), .rst_i(rst_ab),
    .reg_req_i(req_b), .reg_rsp_o(rsp_b),
    .hw_we_i(hwe_b), .hw_wdata_i(hwd_b),
    .reg_q_o(q_b)
  );

  reg_intf_regfile #(
    .NumRegs(4), .WaitCycles(2),
    .ReadOnlyMask(RO), .ResetValue(RV)
  ) u_c (
    .clk_i(clk), .rst_i(rst_c),
    .reg_req_i(req_c), .reg_rsp_o(rsp_c),
    .hw_we_i(hwe_c), .hw_wdata_i(hwd_c),
    .reg_q_o(q_c)
  );

  task automatic bus_a(
    input  logic [31:0] addr,
    input  logic        wr,
    input  logic [31:0] wd,
    input  logic [3:0]  ws,
    input  logic [3:0]  hwe,
    input  logic [31:0] hwword,
    output logic [31:0] rd,
    output logic        er,
    output int          lat
  );
    @(posedge clk); #1;
    req_a = '{addr: addr, write: wr, wdata: wd,
              wstrb: ws, valid: 1'b1};
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rsp_a.ready && lat < 20);
    checks++;
    if (rsp_a.ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_a addr=%h no ready after %0d", addr, lat);
    end
    rd = rsp_a.rdata;
    er = rsp_a.error;
    req_a.valid = 1'b0;
    hwe_a = hwe;
    hwd_a = {4{hwword}};
    @(posedge clk); #1;
    hwe_a = '0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  task automatic test_reset();
    rst_ab = 1'b1;
    rst_c  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rsp_a.ready !== 1'b0) begin
      errors++; $display("FAIL rst_ready got=%b exp=0", rsp_a.ready);
    end
    checks++;
    if (rsp_a.error !== 1'b0) begin
      errors++; $display("FAIL rst_error got=%b exp=0", rsp_a.error);
    end
    checks++;
    if (rsp_a.rdata !== 32'h0) begin
      errors++; $display("FAIL rst_rdata got=%h exp=0", rsp_a.rdata);
    end
    checks++;
    if (q_a !== RV) begin
      errors++; $display("FAIL rst_regs got=%h exp=%h", q_a, RV);
    end
    rst_ab = 1'b0;
    rst_c  = 1'b0;
    bus_a(32'h4, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL rst_read got=%h exp=cafef00d", rd);
    end
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL rst_read_err got=%b exp=0", er);
    end
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL rst_latency got=%0d exp=1", lat);
    end
  endtask

  task automatic test_strobe();
    bus_a(32'h8, 1'b1, 32'h1122_3344, 4'b0101, 4'h0, 32'h0,
          rd, er, lat);
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL strb_wr_err got=%b exp=0", er);
    end
    checks++;
    if (q_a[95:64] !== 32'h0022_0044) begin
      errors++;
      $display("FAIL strb_q got=%h exp=00220044", q_a[95:64]);
    end
    bus_a(32'h8, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0022_0044 || er !== 1'b0) begin
      errors++;
      $display("FAIL strb_rd got=%h/%b exp=00220044/0", rd, er);
    end
  endtask

  task automatic test_errors();
    bus_a(32'h10, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL err_range_rd got=%h/%b exp=0/1", rd, er);
    end
    bus_a(32'h6, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL err_align got=%h/%b exp=0/1", rd, er);
    end
    bus_a(32'h0, 1'b1, 32'hFFFF_FFFF, 4'hF, 4'h0, 32'h0,
          rd, er, lat);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL err_ro got=%b exp=1", er);
    end
    bus_a(32'h10, 1'b1, 32'hFFFF_FFFF, 4'hF, 4'h0, 32'h0,
          rd, er, lat);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL err_range_wr got=%b exp=1", er);
    end
    checks++;
    if (q_a !== {32'h0, 32'h0022_0044, 32'hCAFE_F00D, 32'h0}) begin
      errors++; $display("FAIL err_no_side_effect got=%h", q_a);
    end
  endtask

  task automatic test_wstrb_zero();
    bus_a(32'h8, 1'b1, 32'hDEAD_BEEF, 4'h0, 4'h0, 32'h0,
          rd, er, lat);
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL strb0_err got=%b exp=0", er);
    end
    checks++;
    if (q_a[95:64] !== 32'h0022_0044) begin
      errors++;
      $display("FAIL strb0_q got=%h exp=00220044", q_a[95:64]);
    end
  endtask

  task automatic test_collision();
    bus_a(32'h4, 1'b1, 32'h0, 4'hF, 4'h0, 32'h0, rd, er, lat);
    checks++;
    if (q_a[63:32] !== 32'h0) begin
      errors++; $display("FAIL coll_clear got=%h exp=0", q_a[63:32]);
    end
    bus_a(32'h4, 1'b1, 32'h5555_5555, 4'b0011, 4'b0010,
          32'hAAAA_AAAA, rd, er, lat);
    checks++;
    if (q_a[63:32] !== 32'hAAAA_5555) begin
      errors++;
      $display("FAIL coll_merge got=%h exp=aaaa5555", q_a[63:32]);
    end
  endtask

  task automatic test_hw_write();
    @(posedge clk); #1;
    hwe_a = 4'b1000;
    hwd_a = {4{32'h1234_5678}};
    @(posedge clk); #1;
    hwe_a = '0;
    checks++;
    if (q_a[127:96] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL hw_wr got=%h exp=12345678", q_a[127:96]);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] seen;
    seen = '0;
    @(posedge clk); #1;
    req_b = '{addr: 32'h4, write: 1'b0, wdata: 32'h0,
              wstrb: 4'h0, valid: 1'b1};
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      seen[c] = rsp_b.ready;
      if (rsp_b.ready) begin
        checks++;
        if (rsp_b.rdata !== 32'hCAFE_F00D || rsp_b.error !== 1'b0) begin
          errors++;
          $display("FAIL b2b_rd c=%0d got=%h/%b exp=cafef00d/0",
                   c, rsp_b.rdata, rsp_b.error);
        end
        #3;
        checks++;
        if (rsp_b.rdata !== 32'hCAFE_F00D) begin
          errors++;
          $display("FAIL b2b_hold c=%0d got=%h", c, rsp_b.rdata);
        end
      end
      if (c == 5) begin
        checks++;
        if (rsp_b.rdata !== 32'h0) begin
          errors++;
          $display("FAIL b2b_idle_rdata got=%h exp=0", rsp_b.rdata);
        end
      end
    end
    req_b.valid = 1'b0;
    checks++;
    if (seen !== 11'h210) begin
      errors++; $display("FAIL b2b_ready got=%b exp=01000010000", seen);
    end
    repeat (6) @(posedge clk);
  endtask

  task automatic test_reset_midop();
    logic rdy;
    @(posedge clk); #1;
    req_c = '{addr: 32'h8, write: 1'b1, wdata: 32'hFFFF_FFFF,
              wstrb: 4'hF, valid: 1'b1};
    @(posedge clk); #1;
    rst_c = 1'b1;
    @(posedge clk); #1;
    rst_c = 1'b0;
    req_c.valid = 1'b0;
    rdy = 1'b0;
    repeat (6) begin
      if (rsp_c.ready) rdy = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (rdy !== 1'b0) begin
      errors++; $display("FAIL midop_ready got=1 exp=0");
    end
    checks++;
    if (q_c[95:64] !== 32'h0) begin
      errors++; $display("FAIL midop_reg got=%h exp=0", q_c[95:64]);
    end
    req_c = '{addr: 32'h4, write: 1'b0, wdata: 32'h0,
              wstrb: 4'h0, valid: 1'b1};
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rsp_c.ready && lat < 20);
    checks++;
    if (lat !== 3 || rsp_c.ready !== 1'b1) begin
      errors++; $display("FAIL midop_lat got=%0d exp=3", lat);
    end
    checks++;
    if (rsp_c.rdata !== 32'hCAFE_F00D || rsp_c.error !== 1'b0) begin
      errors++;
      $display("FAIL midop_rd got=%h/%b exp=cafef00d/0",
               rsp_c.rdata, rsp_c.error);
    end
    req_c.valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    req_a = '0; req_b = '0; req_c = '0;
    hwe_a = '0; hwe_b = '0; hwe_c = '0;
    hwd_a = '0; hwd_b = '0; hwd_c = '0;
    rst_ab = 1'b1;
    rst_c  = 1'b1;
    test_reset();
    test_strobe();
    test_errors();
    test_wstrb_zero();
    test_collision();
    test_hw_write();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
